// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state encoding and default sizes.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MDU_MULU = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIVU = 2'b10,
    MDU_DIV  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the execute-stage controller and the MDU.
interface mdu_seq_if import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mdu_negate.sv
// Combinational conditional two's-complement negate.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign o_val = i_neg ? ((~i_val) + ONE) : i_val;

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit: one bit per clock, sign handled by
// operating on magnitudes and correcting the result in a single FIX cycle.
module mdu_seq import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input logic       clk,
  input logic       rst,
  mdu_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nxt;
  mdu_op_e            r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_a;      // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   r_b;      // multiplier (shifts right) or divisor
  logic [2*WIDTH-1:0] r_acc;    // product, or remainder in the upper half
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_div_by_zero;

  logic               w_accept;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_diff;
  logic               w_neg_prod;
  logic               w_neg_quo;
  logic               w_neg_rem;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Operand magnitudes for signed ops are taken straight off the request bus.
  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
    .i_val (bus.A),
    .i_neg (bus.op[0] & bus.A[WIDTH-1]),
    .o_val (w_a_abs)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
    .i_val (bus.B),
    .i_neg (bus.op[0] & bus.B[WIDTH-1]),
    .o_val (w_b_abs)
  );

  // One shift-add / restoring shift-subtract step.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign w_rem_diff = w_rem_sh[WIDTH-1:0] - r_b;

  // With a zero divisor the loop yields quotient all-ones and remainder |A|;
  // keeping the quotient uncorrected and applying the dividend-sign fix to the
  // remainder returns A unmodified in hi.
  assign w_neg_prod = r_op[0] & (r_sign_a ^ r_sign_b);
  assign w_neg_quo  = r_op[0] & (r_sign_a ^ r_sign_b) & ~r_dbz;
  assign w_neg_rem  = r_op[0] & r_sign_a;

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_val (r_acc),
    .i_neg (w_neg_prod),
    .o_val (w_prod_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .i_val (r_a),
    .i_neg (w_neg_quo),
    .o_val (w_quo_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (w_neg_rem),
    .o_val (w_rem_fix)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: start is only honoured in IDLE and DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == LAST_ITER) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = bus.start ? ST_CALC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result correction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op          <= MDU_MULU;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_dbz         <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_op     <= mdu_op_e'(bus.op);
      r_sign_a <= bus.A[WIDTH-1];
      r_sign_b <= bus.B[WIDTH-1];
      r_dbz    <= bus.op[1] & (bus.B == '0);
      r_a      <= w_a_abs;
      r_b      <= w_b_abs;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op[1]) begin
        r_acc[2*WIDTH-1:WIDTH] <= w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
        r_a                    <= {r_a[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
      end
    end else if (r_state == ST_FIX) begin
      if (r_op[1]) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
        r_lo <= w_prod_fix[WIDTH-1:0];
      end
      r_div_by_zero <= r_dbz;
    end
  end

  assign bus.busy        = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: scoreboard of expected {hi, lo, div_by_zero} results,
// one task per scenario.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  res_t sb[$];

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic res_t observed();
    return {bus.hi, bus.lo, bus.div_by_zero};
  endfunction

  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint sa, db, q, m;
    logic [63:0] p;
    sa = op[0] ? longint'($signed(a)) : longint'({32'b0, a});
    db = op[0] ? longint'($signed(b)) : longint'({32'b0, b});
    r.dbz = 1'b0;
    if (!op[1]) begin
      p = sa * db;
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == '0) begin
      r.hi  = a;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else begin
      q = sa / db;
      m = sa % db;
      r.hi = m[31:0];
      r.lo = q[31:0];
    end
    return r;
  endfunction

  // Presents a one-cycle start; returns at the falling edge after the accept edge.
  task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input res_t exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    sb.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; cyc counts rising edges including the accept edge.
  task automatic wait_done(output int cyc, output bit timeout, output bit busy_bad);
    cyc = 1;
    timeout = 1'b0;
    busy_bad = 1'b0;
    while (bus.done !== 1'b1) begin
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (cyc >= 60) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h required all zero",
               bus.busy, bus.done, observed());
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_mulu();
    int cyc; bit to, bb; res_t e;
    drive_start(MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || cyc != 34) begin n_fail++; $display("FAIL mulu_latency: got %0d cycles required 34", cyc); end
    n_tests++;
    if (bb) begin n_fail++; $display("FAIL mulu_busy: busy got 0 before done, required 1"); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mulu_busy_at_done: got %b required 0", bus.busy); end
    n_tests++;
    if (observed() !== e) begin n_fail++; $display("FAIL mulu_result: got %h required %h", observed(), e); end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mulu_done_width: got %b required 0", bus.done); end
  endtask

  task automatic test_signed();
    int cyc; bit to, bb; res_t e;
    drive_start(MDU_MUL, 32'hFFFF_FFFD, 32'd7, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL mul_signed: got %h required %h", observed(), e); end
    drive_start(MDU_DIV, 32'hFFFF_FFF9, 32'd2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL div_signed: got %h required %h", observed(), e); end
  endtask

  task automatic test_div_zero();
    int cyc; bit to, bb; res_t e;
    drive_start(MDU_DIVU, 32'd100, 32'd0, '{hi: 32'd100, lo: 32'hFFFF_FFFF, dbz: 1'b1});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || cyc != 34 || observed() !== e) begin
      n_fail++; $display("FAIL divu_by_zero: got %h after %0d cycles required %h after 34", observed(), cyc, e);
    end
    drive_start(MDU_DIVU, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL divu_after_zero: got %h required %h", observed(), e); end
    drive_start(MDU_DIV, 32'hFFFF_FFFB, 32'd0, '{hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF, dbz: 1'b1});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL div_signed_by_zero: got %h required %h", observed(), e); end
  endtask

  task automatic test_overflow();
    int cyc; bit to, bb; res_t e;
    drive_start(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0, lo: 32'h8000_0000, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL div_overflow: got %h required %h", observed(), e); end
  endtask

  task automatic test_ignore_start();
    int cyc, ndone; bit to, bb; res_t e;
    drive_start(MDU_MULU, 32'd3, 32'd5, '{hi: 32'h0, lo: 32'd15, dbz: 1'b0});
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.A = 32'd100; bus.B = 32'd100;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL ignore_start_result: got %h required %h", observed(), e); end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin n_fail++; $display("FAIL ignore_start_extra_op: got %0d active cycles required 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int cyc, t1, t2; bit to, bb; res_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULU; bus.A = 32'd2; bus.B = 32'd3;
    sb.push_back('{hi: 32'h0, lo: 32'd6, dbz: 1'b0});
    @(negedge clk);
    bus.A = 32'd4; bus.B = 32'd5;
    sb.push_back('{hi: 32'h0, lo: 32'd20, dbz: 1'b0});
    wait_done(cyc, to, bb);
    t1 = cycle;
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL b2b_first: got %h required %h", observed(), e); end
    @(negedge clk);
    bus.start = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_accept_in_done: got busy=%b done=%b required 1 0", bus.busy, bus.done);
    end
    wait_done(cyc, to, bb);
    t2 = cycle;
    e = sb.pop_front();
    n_tests++;
    if (to || (t2 - t1) != 34) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles required 34", t2 - t1); end
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL b2b_second: got %h required %h", observed(), e); end
  endtask

  task automatic test_operand_change();
    int cyc; bit to, bb; res_t e;
    drive_start(MDU_DIVU, 32'd1000, 32'd9, '{hi: 32'd1, lo: 32'd111, dbz: 1'b0});
    bus.op = MDU_MUL; bus.A = 32'hDEAD_BEEF; bus.B = 32'h0;
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL operand_change: got %h required %h", observed(), e); end
  endtask

  task automatic test_reset_mid();
    int cyc, nact; bit to, bb; res_t e;
    drive_start(MDU_MULU, 32'hFFFF_FFFF, 32'd2, model(MDU_MULU, 32'hFFFF_FFFF, 32'd2));
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    n_tests++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b res=%h required all zero",
               bus.busy, bus.done, observed());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nact = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) nact++;
    end
    n_tests++;
    if (nact != 0) begin n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles required 0", nact); end
    drive_start(MDU_MULU, 32'd6, 32'd7, '{hi: 32'h0, lo: 32'd42, dbz: 1'b0});
    wait_done(cyc, to, bb);
    e = sb.pop_front();
    n_tests++;
    if (to || observed() !== e) begin n_fail++; $display("FAIL reset_mid_recover: got %h required %h", observed(), e); end
  endtask

  task automatic test_random();
    int cyc; bit to, bb; res_t e;
    logic [1:0] op; logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 2 == 1) b = b >> $urandom_range(0, 28);
      if (i == 6) b = '0;
      drive_start(op, a, b, model(op, a, b));
      wait_done(cyc, to, bb);
      e = sb.pop_front();
      n_tests++;
      if (to || bb || observed() !== e) begin
        n_fail++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h required %h", i, op, a, b, observed(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mulu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_operand_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
